hazard_ctrl: RTL and testbench

- Consumes the forwarding unit's load-use stall indication, plus branch-redirect, data-memory busy and trap events.
- Produces per-stage stall and flush (bubble) controls for the 5-stage pipeline (IF, ID, EX, MEM, WB).
- A small FSM sequences load-use bubbles, multi-cycle memory waits and a timeout fault.
- Sits beside the pipeline registers; its outputs drive their enable and clear inputs.

---
 rtl/hazard_ctrl_pkg.sv | 25 ++
 rtl/hazard_ctrl_hz_timeout_cnt.sv | 41 ++++
 rtl/hazard_ctrl.sv | 144 ++++++++++++++
 tb/tb_hazard_ctrl.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared types and defaults for the 5-stage pipeline hazard controller.
package hazard_pkg;

    localparam int MEM_TIMEOUT_DEF = 16;
    localparam int CNT_W_DEF       = 32;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        MEM_WAIT = 2'd2,
        FAULT    = 2'd3
    } hz_state_e;

    typedef struct packed {
        logic stall_if;
        logic stall_id;
        logic stall_ex;
        logic stall_mem;
        logic flush_id;
        logic flush_ex;
        logic flush_mem;
        logic flush_wb;
    } pipe_ctrl_t;

endpackage

// File: rtl/hazard_ctrl_hz_timeout_cnt.sv
// Saturating dmem-busy counter; hit_o flags the busy cycle that brings the
// count to MEM_TIMEOUT.
module hz_timeout_cnt
    import hazard_pkg::*;
#(
    parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF,
    localparam int CW = $clog2(MEM_TIMEOUT + 1)
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic inc_i,
    output logic hit_o
);

    localparam logic [CW-1:0] CntMax = CW'(MEM_TIMEOUT);
    localparam logic [CW-1:0] CntPre = CW'(MEM_TIMEOUT - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != CntMax)) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // The current busy cycle is counted too, so the hit fires one step early.
    assign hit_o = inc_i && (cnt_q >= CntPre);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: per-stage stall/flush for IF..WB.
// Optional performance counters enabled by defining HAZARD_PERF_CNT_EN.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic load_use_stall_i,
    input  logic branch_taken_i,
    input  logic dmem_busy_i,
    input  logic trap_i,
    output logic stall_if_o,
    output logic stall_id_o,
    output logic stall_ex_o,
    output logic stall_mem_o,
    output logic flush_id_o,
    output logic flush_ex_o,
    output logic flush_mem_o,
    output logic flush_wb_o,
    output logic mem_fault_o
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] lu_stall_cnt_o,
    output logic [CNT_W-1:0] mem_wait_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
`endif
);

    localparam logic [1:0] S_RUN      = RUN;
    localparam logic [1:0] S_LU_STALL = LU_STALL;
    localparam logic [1:0] S_MEM_WAIT = MEM_WAIT;
    localparam logic [1:0] S_FAULT    = FAULT;

    if (MEM_TIMEOUT < 2 || CNT_W < 1) begin : g_bad_param
        $error("hazard_ctrl: MEM_TIMEOUT must be >= 2 and CNT_W >= 1");
    end

    logic [1:0] state_q, state_d;
    pipe_ctrl_t ctrl;
    logic       fault;
    logic       busy_eff;
    logic       tmo_hit;
    logic       tmo_clr;

    // Busy is not serviced while a trap commits or while reporting a fault.
    assign busy_eff = dmem_busy_i && !trap_i && (state_q != S_FAULT);
    assign tmo_clr  = !busy_eff || tmo_hit;

    hz_timeout_cnt #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_tmo (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (tmo_clr),
        .inc_i (busy_eff),
        .hit_o (tmo_hit)
    );

    always_comb begin
        ctrl    = '0;
        fault   = 1'b0;
        state_d = S_RUN;
        if (trap_i) begin
            ctrl.flush_id  = 1'b1;
            ctrl.flush_ex  = 1'b1;
            ctrl.flush_mem = 1'b1;
        end else if (state_q == S_FAULT) begin
            ctrl.flush_id = 1'b1;
        end else if (busy_eff) begin
            if (tmo_hit) begin
                fault          = 1'b1;
                ctrl.flush_id  = 1'b1;
                ctrl.flush_ex  = 1'b1;
                ctrl.flush_mem = 1'b1;
                ctrl.flush_wb  = 1'b1;
                state_d        = S_FAULT;
            end else begin
                ctrl.stall_if  = 1'b1;
                ctrl.stall_id  = 1'b1;
                ctrl.stall_ex  = 1'b1;
                ctrl.stall_mem = 1'b1;
                ctrl.flush_wb  = 1'b1;
                state_d        = S_MEM_WAIT;
            end
        end else if (branch_taken_i) begin
            ctrl.flush_id = 1'b1;
            ctrl.flush_ex = 1'b1;
        end else if (load_use_stall_i && (state_q != S_LU_STALL)) begin
            // The load has moved on to MEM after one bubble; forwarding covers it.
            ctrl.stall_if = 1'b1;
            ctrl.stall_id = 1'b1;
            ctrl.flush_ex = 1'b1;
            state_d       = S_LU_STALL;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    assign stall_if_o  = !rst_i && ctrl.stall_if;
    assign stall_id_o  = !rst_i && ctrl.stall_id;
    assign stall_ex_o  = !rst_i && ctrl.stall_ex;
    assign stall_mem_o = !rst_i && ctrl.stall_mem;
    assign flush_id_o  = !rst_i && ctrl.flush_id;
    assign flush_ex_o  = !rst_i && ctrl.flush_ex;
    assign flush_mem_o = !rst_i && ctrl.flush_mem;
    assign flush_wb_o  = !rst_i && ctrl.flush_wb;
    assign mem_fault_o = !rst_i && fault;

`ifdef HAZARD_PERF_CNT_EN
    logic             lu_ev, flush_ev;
    logic [CNT_W-1:0] lu_cnt_q, mem_cnt_q, flush_cnt_q;

    // Load-use is the only case stalling IF without MEM; branch flush is the
    // only flush pattern touching ID and EX but not MEM.
    assign lu_ev    = ctrl.stall_if && !ctrl.stall_mem;
    assign flush_ev = trap_i || (ctrl.flush_id && ctrl.flush_ex && !ctrl.flush_mem);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lu_cnt_q    <= '0;
            mem_cnt_q   <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (lu_ev)    lu_cnt_q    <= lu_cnt_q + CNT_W'(1);
            if (busy_eff) mem_cnt_q   <= mem_cnt_q + CNT_W'(1);
            if (flush_ev) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
        end
    end

    assign lu_stall_cnt_o = lu_cnt_q;
    assign mem_wait_cnt_o = mem_cnt_q;
    assign flush_cnt_o    = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: one instance at the default timeout and one
// at MEM_TIMEOUT = 4, both driven by the same inputs.
module tb_hazard_ctrl;

    logic clk = 1'b0;
    logic rst;
    logic lu, br, busy, trap;

    logic s_if_a, s_id_a, s_ex_a, s_mem_a, f_id_a, f_ex_a, f_mem_a, f_wb_a, flt_a;
    logic s_if_b, s_id_b, s_ex_b, s_mem_b, f_id_b, f_ex_b, f_mem_b, f_wb_b, flt_b;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] lu_cnt_a, mem_cnt_a, fl_cnt_a;
    logic [31:0] lu_cnt_b, mem_cnt_b, fl_cnt_b;
`endif

    logic [8:0] obs16, obs4;
    assign obs16 = {s_if_a, s_id_a, s_ex_a, s_mem_a, f_id_a, f_ex_a, f_mem_a, f_wb_a, flt_a};
    assign obs4  = {s_if_b, s_id_b, s_ex_b, s_mem_b, f_id_b, f_ex_b, f_mem_b, f_wb_b, flt_b};

    // {stall_if,id,ex,mem, flush_id,ex,mem,wb, fault}
    localparam logic [8:0] NONE  = 9'b0000_0000_0;
    localparam logic [8:0] LUST  = 9'b1100_0100_0;
    localparam logic [8:0] BRFL  = 9'b0000_1100_0;
    localparam logic [8:0] BUSY  = 9'b1111_0001_0;
    localparam logic [8:0] TMO   = 9'b0000_1111_1;
    localparam logic [8:0] FLTST = 9'b0000_1000_0;
    localparam logic [8:0] TRAP  = 9'b0000_1110_0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    hazard_ctrl dut16 (
        .clk_i(clk), .rst_i(rst),
        .load_use_stall_i(lu), .branch_taken_i(br), .dmem_busy_i(busy), .trap_i(trap),
        .stall_if_o(s_if_a), .stall_id_o(s_id_a), .stall_ex_o(s_ex_a), .stall_mem_o(s_mem_a),
        .flush_id_o(f_id_a), .flush_ex_o(f_ex_a), .flush_mem_o(f_mem_a), .flush_wb_o(f_wb_a),
        .mem_fault_o(flt_a)
`ifdef HAZARD_PERF_CNT_EN
        , .lu_stall_cnt_o(lu_cnt_a), .mem_wait_cnt_o(mem_cnt_a), .flush_cnt_o(fl_cnt_a)
`endif
    );

    hazard_ctrl #(.MEM_TIMEOUT(4)) dut4 (
        .clk_i(clk), .rst_i(rst),
        .load_use_stall_i(lu), .branch_taken_i(br), .dmem_busy_i(busy), .trap_i(trap),
        .stall_if_o(s_if_b), .stall_id_o(s_id_b), .stall_ex_o(s_ex_b), .stall_mem_o(s_mem_b),
        .flush_id_o(f_id_b), .flush_ex_o(f_ex_b), .flush_mem_o(f_mem_b), .flush_wb_o(f_wb_b),
        .mem_fault_o(flt_b)
`ifdef HAZARD_PERF_CNT_EN
        , .lu_stall_cnt_o(lu_cnt_b), .mem_wait_cnt_o(mem_cnt_b), .flush_cnt_o(fl_cnt_b)
`endif
    );

    // Apply one cycle of inputs after the falling edge and settle before checks.
    task automatic cyc(input logic l, input logic b, input logic m, input logic t);
        @(negedge clk);
        lu = l; br = b; busy = m; trap = t;
        #1;
    endtask

    task automatic test_reset;
        #1;
        checks++;
        if (obs16 !== NONE) begin errors++; $display("FAIL reset_out got %b want %b", obs16, NONE); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (obs16 !== NONE || obs4 !== NONE) begin
            errors++; $display("FAIL reset_idle got %b/%b want %b", obs16, obs4, NONE);
        end
    endtask

    task automatic test_load_use;
        cyc(1, 0, 0, 0);
        checks++;
        if (obs16 !== LUST) begin errors++; $display("FAIL lu_c0 got %b want %b", obs16, LUST); end
        cyc(1, 0, 0, 0);
        checks++;
        if (obs16 !== NONE) begin errors++; $display("FAIL lu_c1_masked got %b want %b", obs16, NONE); end
        cyc(1, 0, 0, 0);
        checks++;
        if (obs16 !== LUST) begin errors++; $display("FAIL lu_c2 got %b want %b", obs16, LUST); end
        cyc(0, 0, 0, 0);
        checks++;
        if (obs16 !== NONE) begin errors++; $display("FAIL lu_c3 got %b want %b", obs16, NONE); end
    endtask

    task automatic test_branch_over_lu;
        cyc(1, 1, 0, 0);
        checks++;
        if (obs16 !== BRFL) begin errors++; $display("FAIL br_lu got %b want %b", obs16, BRFL); end
        cyc(1, 0, 0, 0);
        checks++;
        if (obs16 !== LUST) begin errors++; $display("FAIL br_next_run got %b want %b", obs16, LUST); end
        cyc(0, 0, 0, 0);
    endtask

    task automatic test_mem_busy;
        cyc(0, 0, 1, 0);
        checks++;
        if (obs16 !== BUSY) begin errors++; $display("FAIL busy_c1 got %b want %b", obs16, BUSY); end
        cyc(1, 1, 1, 0);
        checks++;
        if (obs16 !== BUSY) begin errors++; $display("FAIL busy_c2_ignore got %b want %b", obs16, BUSY); end
        cyc(0, 0, 1, 0);
        checks++;
        if (obs16 !== BUSY || obs4 !== BUSY) begin
            errors++; $display("FAIL busy_c3 got %b/%b want %b", obs16, obs4, BUSY);
        end
        cyc(0, 0, 0, 0);
        checks++;
        if (obs16 !== NONE || obs4 !== NONE) begin
            errors++; $display("FAIL busy_release got %b/%b want %b", obs16, obs4, NONE);
        end
    endtask

    task automatic test_mem_timeout;
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 1, 0);
            checks++;
            if (obs4 !== BUSY) begin errors++; $display("FAIL tmo_wait%0d got %b want %b", i, obs4, BUSY); end
        end
        cyc(0, 0, 1, 0);
        checks++;
        if (obs4 !== TMO) begin errors++; $display("FAIL tmo_hit got %b want %b", obs4, TMO); end
        checks++;
        if (obs16 !== BUSY) begin errors++; $display("FAIL tmo_no_hit16 got %b want %b", obs16, BUSY); end
        cyc(0, 0, 0, 0);
        checks++;
        if (obs4 !== FLTST) begin errors++; $display("FAIL tmo_fault_state got %b want %b", obs4, FLTST); end
        cyc(0, 0, 0, 0);
        checks++;
        if (obs4 !== NONE || obs16 !== NONE) begin
            errors++; $display("FAIL tmo_back_run got %b/%b want %b", obs4, obs16, NONE);
        end
    endtask

    task automatic test_trap;
        cyc(0, 0, 1, 0);
        cyc(1, 1, 1, 1);
        checks++;
        if (obs16 !== TRAP) begin errors++; $display("FAIL trap_flush got %b want %b", obs16, TRAP); end
        cyc(1, 0, 0, 0);
        checks++;
        if (obs16 !== LUST) begin errors++; $display("FAIL trap_next_run got %b want %b", obs16, LUST); end
        cyc(0, 0, 0, 0);
    endtask

    task automatic test_reset_mid_wait;
        for (int i = 0; i < 5; i++) cyc(0, 0, 1, 0);
        @(negedge clk);
        #1;
        checks++;
        if (obs16 !== BUSY) begin errors++; $display("FAIL mid_wait_pre got %b want %b", obs16, BUSY); end
        rst = 1'b1;
        #1;
        checks++;
        if (obs16 !== NONE || obs4 !== NONE) begin
            errors++; $display("FAIL mid_wait_async got %b/%b want %b", obs16, obs4, NONE);
        end
        @(negedge clk);
        rst = 1'b0; busy = 1'b0;
        #1;
        checks++;
        if (obs16 !== NONE) begin errors++; $display("FAIL mid_wait_release got %b want %b", obs16, NONE); end
        cyc(1, 0, 0, 0);
        checks++;
        if (obs16 !== LUST) begin errors++; $display("FAIL mid_wait_run got %b want %b", obs16, LUST); end
        cyc(0, 0, 0, 0);
    endtask

`ifdef HAZARD_PERF_CNT_EN
    task automatic test_perf;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc(1, 0, 0, 0);
            cyc(0, 0, 0, 0);
        end
        for (int i = 0; i < 5; i++) cyc(0, 0, 1, 0);
        cyc(0, 0, 0, 0);
        cyc(0, 1, 0, 0);
        cyc(0, 1, 0, 0);
        cyc(0, 0, 0, 0);
        checks++;
        if (lu_cnt_a !== 32'd3) begin errors++; $display("FAIL perf_lu got %0d want 3", lu_cnt_a); end
        checks++;
        if (mem_cnt_a !== 32'd5) begin errors++; $display("FAIL perf_mem got %0d want 5", mem_cnt_a); end
        checks++;
        if (fl_cnt_a !== 32'd2) begin errors++; $display("FAIL perf_flush got %0d want 2", fl_cnt_a); end
    endtask
`endif

    initial begin
        rst = 1'b1; lu = 1'b0; br = 1'b0; busy = 1'b0; trap = 1'b0;
        test_reset;
        test_load_use;
        test_branch_over_lu;
        test_mem_busy;
        test_mem_timeout;
        test_trap;
        test_reset_mid_wait;
`ifdef HAZARD_PERF_CNT_EN
        test_perf;
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
